// File: rtl/array_regpx_pkg.sv
// Shared definitions for the multi-port parity-checked register array:
// FSM encoding and the saturating error-count helper.
package array_regpx_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   localparam int unsigned MAXRD = 4;

   // acc + popcount(vec), clamped to the all-ones value of a w-bit counter
   function automatic logic [31:0] sat_add_pop(input logic [31:0]      acc,
                                               input logic [MAXRD-1:0] vec,
                                               input int unsigned      w);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, acc};
      for (int i = 0; i < MAXRD; i++) begin
         sum = sum + 33'(vec[i]);
      end
      lim = (33'd1 << w) - 33'd1;
      return (sum > lim) ? lim[31:0] : sum[31:0];
   endfunction

endpackage

// File: rtl/array_regpx_rdport.sv
// One read port: output register with bypass/out-of-range mux, the stored
// parity bit carried alongside, and the resulting mismatch flag.
module array_regpx_rdport
   import array_regpx_pkg::*;
#(
   parameter int ADDRBIT = 9,
   parameter int WIDTH   = 32,
   parameter int BYPASS  = 1
)(
   input  logic               clk,
   input  logic               rst_,
   input  logic               en_i,
   input  logic               oob_i,
   input  logic               hit_i,
   input  logic [ADDRBIT-1:0] ra_i,
   input  logic [WIDTH-1:0]   rdata_i,
   input  logic               rpar_i,
   input  logic [WIDTH-1:0]   di_i,
   output logic [WIDTH-1:0]   do_o,
   output logic               dvld_o,
   output logic               mm_o,
   output logic [ADDRBIT-1:0] addr_o
);

   logic [WIDTH-1:0]   do_q, do_d;
   logic               chk_q, chk_d;
   logic               dvld_q;
   logic               par_q;
   logic [ADDRBIT-1:0] addr_q;

   // Bypassed and out-of-range reads carry no stored parity, so they are never checked
   always_comb begin
      do_d  = rdata_i;
      chk_d = 1'b1;
      if (oob_i) begin
         do_d  = '0;
         chk_d = 1'b0;
      end else if (hit_i && (BYPASS != 0)) begin
         do_d  = di_i;
         chk_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         do_q   <= '0;
         dvld_q <= 1'b0;
         chk_q  <= 1'b0;
         par_q  <= 1'b0;
         addr_q <= '0;
      end else begin
         dvld_q <= en_i;
         if (en_i) begin
            do_q   <= do_d;
            chk_q  <= chk_d;
            par_q  <= rpar_i;
            addr_q <= ra_i;
         end
      end
   end

   assign do_o   = do_q;
   assign dvld_o = dvld_q;
   assign mm_o   = dvld_q & chk_q & (par_q ^ (^do_q));
   assign addr_o = addr_q;

endmodule

// File: rtl/array_regpx_mp.sv
// Register array with one write port, NRD parity-checked read ports, a
// hardware zero-fill sweep instead of a reset, and first-error diagnostics.
module array_regpx_mp
   import array_regpx_pkg::*;
#(
   parameter int ADDRBIT = 9,
   parameter int DEPTH   = 512,
   parameter int WIDTH   = 32,
   parameter int NRD     = 3,
   parameter int PORTBIT = 2,
   parameter int BYPASS  = 1,
   parameter int ERRCNTW = 8
)(
   input  logic                   clk,
   input  logic                   rst_,
   input  logic                   init_req,
   output logic                   init_busy,
   input  logic [ADDRBIT-1:0]     wa,
   input  logic                   we,
   input  logic [WIDTH-1:0]       di,
   input  logic [NRD-1:0]         re,
   input  logic [NRD*ADDRBIT-1:0] ra,
   output logic [NRD*WIDTH-1:0]   do_o,
   output logic [NRD-1:0]         dvld,
   input  logic [1:0]             par_ctrl,
   output logic                   par_err,
   output logic [ADDRBIT-1:0]     par_err_addr,
   output logic [PORTBIT-1:0]     par_err_port,
   output logic [ERRCNTW-1:0]     par_err_cnt
);

   localparam logic [ADDRBIT:0]   DEPTH_L = (ADDRBIT+1)'(DEPTH);
   localparam logic [ADDRBIT-1:0] LAST_A  = ADDRBIT'(DEPTH-1);

   logic [WIDTH-1:0]   mem_q     [DEPTH];
   logic               par_mem_q [DEPTH];
   state_e             st_q;
   logic [ADDRBIT-1:0] swp_q;
   logic               ready;
   logic               wr_ok;

   assign ready     = rst_ & (st_q == ST_READY);
   assign wr_ok     = ready & we & ({1'b0, wa} < DEPTH_L);
   assign init_busy = rst_ & (st_q == ST_INIT);

   always_ff @(posedge clk) begin
      if (!rst_) begin
         st_q  <= ST_INIT;
         swp_q <= '0;
      end else begin
         case (st_q)
            ST_INIT: begin
               if (swp_q == LAST_A) begin
                  st_q  <= ST_READY;
                  swp_q <= '0;
               end else begin
                  swp_q <= swp_q + 1'b1;
               end
            end
            ST_READY: begin
               if (init_req) begin
                  st_q  <= ST_INIT;
                  swp_q <= '0;
               end
            end
            default: st_q <= ST_INIT;
         endcase
      end
   end

   // Storage has no reset so it can map onto RAM; the sweep zeroes it instead
   always_ff @(posedge clk) begin
      if (rst_ && (st_q == ST_INIT)) begin
         mem_q[swp_q]     <= '0;
         par_mem_q[swp_q] <= 1'b0;
      end else if (wr_ok) begin
         mem_q[wa] <= di;
         if (!par_ctrl[1]) begin
            par_mem_q[wa] <= ^di;
         end
      end
   end

   logic [NRD-1:0]     mm;
   logic [ADDRBIT-1:0] rd_addr [NRD];

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [ADDRBIT-1:0] ra_p;
      assign ra_p = ra[p*ADDRBIT +: ADDRBIT];

      array_regpx_rdport #(
         .ADDRBIT (ADDRBIT),
         .WIDTH   (WIDTH),
         .BYPASS  (BYPASS)
      ) u_rd (
         .clk     (clk),
         .rst_    (rst_),
         .en_i    (ready & re[p]),
         .oob_i   ({1'b0, ra_p} >= DEPTH_L),
         .hit_i   (wr_ok & (wa == ra_p)),
         .ra_i    (ra_p),
         .rdata_i (mem_q[ra_p]),
         .rpar_i  (par_mem_q[ra_p]),
         .di_i    (di),
         .do_o    (do_o[p*WIDTH +: WIDTH]),
         .dvld_o  (dvld[p]),
         .mm_o    (mm[p]),
         .addr_o  (rd_addr[p])
      );
   end

   logic                   err_q, err_d;
   logic [ADDRBIT-1:0]     eaddr_q, eaddr_d;
   logic [PORTBIT-1:0]     eport_q, eport_d;
   logic [ERRCNTW-1:0]     ecnt_q, ecnt_d;
   logic [ADDRBIT-1:0]     faddr;
   logic [PORTBIT-1:0]     fport;

   // A mismatch arriving together with a clear becomes the first post-clear error
   always_comb begin
      faddr   = '0;
      fport   = '0;
      for (int p = NRD-1; p >= 0; p--) begin
         if (mm[p]) begin
            faddr = rd_addr[p];
            fport = PORTBIT'(p);
         end
      end
      err_d   = err_q;
      eaddr_d = eaddr_q;
      eport_d = eport_q;
      ecnt_d  = ecnt_q;
      if (|mm) begin
         err_d = 1'b1;
         if (!err_q || par_ctrl[0]) begin
            eaddr_d = faddr;
            eport_d = fport;
         end
         ecnt_d = ERRCNTW'(sat_add_pop(par_ctrl[0] ? 32'd0 : 32'(ecnt_q), 4'(mm), ERRCNTW));
      end else if (par_ctrl[0]) begin
         err_d   = 1'b0;
         eaddr_d = '0;
         eport_d = '0;
         ecnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         err_q   <= 1'b0;
         eaddr_q <= '0;
         eport_q <= '0;
         ecnt_q  <= '0;
      end else begin
         err_q   <= err_d;
         eaddr_q <= eaddr_d;
         eport_q <= eport_d;
         ecnt_q  <= ecnt_d;
      end
   end

   assign par_err      = err_q;
   assign par_err_addr = eaddr_q;
   assign par_err_port = eport_q;
   assign par_err_cnt  = ecnt_q;

endmodule

// File: tb/tb_array_regpx_mp.sv
// Bench for array_regpx_mp: a default instance and a variant (DEPTH=500,
// BYPASS=0, ERRCNTW=2) share stimulus and are compared to a reference model.
module tb_array_regpx_mp;

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic        init_req = 1'b0;
   logic        we = 1'b0;
   logic [8:0]  wa = '0;
   logic [31:0] di = '0;
   logic [2:0]  re = '0;
   logic [26:0] ra = '0;
   logic [1:0]  par_ctrl = '0;

   logic        busy_m, busy_a, err_m, err_a;
   logic [95:0] do_m, do_a;
   logic [2:0]  dvld_m, dvld_a;
   logic [8:0]  eaddr_m, eaddr_a;
   logic [1:0]  eport_m, eport_a;
   logic [7:0]  ecnt_m;
   logic [1:0]  ecnt_a;

   always #5 clk = ~clk;

   array_regpx_mp u_main (
      .clk(clk), .rst_(rst_), .init_req(init_req), .init_busy(busy_m),
      .wa(wa), .we(we), .di(di), .re(re), .ra(ra), .do_o(do_m), .dvld(dvld_m),
      .par_ctrl(par_ctrl), .par_err(err_m), .par_err_addr(eaddr_m),
      .par_err_port(eport_m), .par_err_cnt(ecnt_m)
   );

   array_regpx_mp #(.DEPTH(500), .BYPASS(0), .ERRCNTW(2)) u_alt (
      .clk(clk), .rst_(rst_), .init_req(init_req), .init_busy(busy_a),
      .wa(wa), .we(we), .di(di), .re(re), .ra(ra), .do_o(do_a), .dvld(dvld_a),
      .par_ctrl(par_ctrl), .par_err(err_a), .par_err_addr(eaddr_a),
      .par_err_port(eport_a), .par_err_cnt(ecnt_a)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model, instance 0 = default, 1 = variant
   logic [31:0] mmem   [2][512];
   logic        mpar   [2][512];
   int          left   [2];
   logic [31:0] xdo    [2][3];
   logic        xdvld  [2][3];
   logic        pend   [2][3];
   logic [8:0]  paddr  [2][3];
   logic        xerr   [2];
   logic [8:0]  xeaddr [2];
   logic [1:0]  xeport [2];
   int          xecnt  [2];

   task automatic clear_mem(input int i);
      for (int a = 0; a < 512; a++) begin
         mmem[i][a] = '0;
         mpar[i][a] = 1'b0;
      end
   endtask

   task automatic model_edge();
      int dep, cm, n, first, a, w;
      bit bp, hit;
      for (int i = 0; i < 2; i++) begin
         dep = (i == 0) ? 512 : 500;
         cm  = (i == 0) ? 255 : 3;
         bp  = (i == 0);
         if (!rst_) begin
            left[i] = dep;
            clear_mem(i);
            for (int p = 0; p < 3; p++) begin
               xdo[i][p] = '0; xdvld[i][p] = 1'b0; pend[i][p] = 1'b0; paddr[i][p] = '0;
            end
            xerr[i] = 1'b0; xeaddr[i] = '0; xeport[i] = '0; xecnt[i] = 0;
         end else begin
            n = 0; first = -1;
            for (int p = 0; p < 3; p++) begin
               if (pend[i][p]) begin
                  n++;
                  if (first < 0) first = p;
               end
            end
            if (n > 0) begin
               if (!xerr[i] || par_ctrl[0]) begin
                  xeaddr[i] = paddr[i][first];
                  xeport[i] = 2'(first);
               end
               xecnt[i] = (par_ctrl[0] ? 0 : xecnt[i]) + n;
               if (xecnt[i] > cm) xecnt[i] = cm;
               xerr[i] = 1'b1;
            end else if (par_ctrl[0]) begin
               xerr[i] = 1'b0; xeaddr[i] = '0; xeport[i] = '0; xecnt[i] = 0;
            end
            if (left[i] > 0) begin
               left[i]--;
               for (int p = 0; p < 3; p++) begin
                  xdvld[i][p] = 1'b0; pend[i][p] = 1'b0;
               end
            end else begin
               w = int'(wa);
               for (int p = 0; p < 3; p++) begin
                  pend[i][p] = 1'b0;
                  xdvld[i][p] = re[p];
                  if (re[p]) begin
                     a = int'(ra[p*9 +: 9]);
                     paddr[i][p] = ra[p*9 +: 9];
                     hit = we && (w == a) && (w < dep);
                     if (a >= dep) xdo[i][p] = '0;
                     else if (hit && bp) xdo[i][p] = di;
                     else begin
                        xdo[i][p] = mmem[i][a];
                        pend[i][p] = (mpar[i][a] != ^mmem[i][a]);
                     end
                  end
               end
               if (we && w < dep) begin
                  mmem[i][w] = di;
                  if (!par_ctrl[1]) mpar[i][w] = ^di;
               end
               if (init_req) begin
                  left[i] = dep;
                  clear_mem(i);
               end
            end
         end
      end
   endtask

   task automatic cmp_inst(input int i, input logic busy, input logic [95:0] dout,
                           input logic [2:0] dv, input logic e, input logic [8:0] ea,
                           input logic [1:0] ep, input logic [7:0] ec);
      chk($sformatf("i%0d_init_busy", i), 32'(busy), 32'(rst_ && (left[i] > 0)));
      for (int p = 0; p < 3; p++) begin
         chk($sformatf("i%0d_dvld%0d", i, p), 32'(dv[p]), 32'(xdvld[i][p]));
         chk($sformatf("i%0d_do%0d", i, p), dout[p*32 +: 32], xdo[i][p]);
      end
      chk($sformatf("i%0d_par_err", i), 32'(e), 32'(xerr[i]));
      chk($sformatf("i%0d_err_addr", i), 32'(ea), 32'(xeaddr[i]));
      chk($sformatf("i%0d_err_port", i), 32'(ep), 32'(xeport[i]));
      chk($sformatf("i%0d_err_cnt", i), 32'(ec), 32'(xecnt[i]));
   endtask

   // Inputs are set at the falling edge; one call = one rising edge + full check
   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      cmp_inst(0, busy_m, do_m, dvld_m, err_m, eaddr_m, eport_m, ecnt_m);
      cmp_inst(1, busy_a, do_a, dvld_a, err_a, eaddr_a, eport_a, {6'b0, ecnt_a});
   endtask

   task automatic idle();
      we = 1'b0; wa = '0; di = '0; re = '0; ra = '0; par_ctrl = '0; init_req = 1'b0;
   endtask

   task automatic wait_ready(input int start, output int nm, output int na);
      int n;
      n = start; nm = 0; na = 0;
      while ((busy_m || busy_a) && (n < start + 700)) begin
         step();
         n++;
         if (!busy_a && na == 0) na = n;
         if (!busy_m && nm == 0) nm = n;
      end
   endtask

   function automatic logic [8:0] rnd_addr();
      if ($urandom_range(0, 7) == 0) return 9'($urandom_range(490, 511));
      return 9'($urandom_range(0, 15));
   endfunction

   typedef struct {
      int unsigned we, wa, di, re, ra0, ra1, ra2, pc;
      int unsigned x_dvld, x_do0, x_do1, x_do2, x_err, x_eaddr, x_eport, x_ecnt;
      int unsigned x_ado0, x_acnt;
   } vec_t;

   vec_t vt [19];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nm, na, dseen;
      logic [2:0] xd;

      //          we wa  di            re ra0 ra1 ra2 pc  dvld do0           do1           do2           err ea ep ec  ado0          acnt
      vt[0]  = '{0, 0,   0,            1, 5,  0,  0,  0,  1,   0,            0,            0,            0,  0, 0, 0,  0,            0};
      vt[1]  = '{1, 7,   32'hA5A50001, 0, 0,  0,  0,  0,  0,   0,            0,            0,            0,  0, 0, 0,  0,            0};
      vt[2]  = '{0, 0,   0,            7, 7,  7,  7,  0,  7,   32'hA5A50001, 32'hA5A50001, 32'hA5A50001, 0,  0, 0, 0,  32'hA5A50001, 0};
      vt[3]  = '{1, 3,   1,            0, 0,  0,  0,  2,  0,   0,            0,            0,            0,  0, 0, 0,  0,            0};
      vt[4]  = '{0, 0,   0,            4, 0,  0,  3,  0,  4,   0,            0,            1,            0,  0, 0, 0,  0,            0};
      vt[5]  = '{0, 0,   0,            0, 0,  0,  0,  0,  0,   0,            0,            0,            1,  3, 2, 1,  0,            1};
      vt[6]  = '{0, 0,   0,            0, 0,  0,  0,  1,  0,   0,            0,            0,            0,  0, 0, 0,  0,            0};
      vt[7]  = '{1, 4,   1,            0, 0,  0,  0,  2,  0,   0,            0,            0,            0,  0, 0, 0,  0,            0};
      vt[8]  = '{1, 6,   32'h10,       0, 0,  0,  0,  2,  0,   0,            0,            0,            0,  0, 0, 0,  0,            0};
      vt[9]  = '{0, 0,   0,            3, 6,  4,  0,  0,  3,   32'h10,       1,            0,            0,  0, 0, 0,  32'h10,       0};
      vt[10] = '{0, 0,   0,            0, 0,  0,  0,  0,  0,   0,            0,            0,            1,  6, 0, 2,  0,            2};
      vt[11] = '{0, 0,   0,            3, 6,  4,  0,  0,  3,   32'h10,       1,            0,            1,  6, 0, 2,  32'h10,       2};
      vt[12] = '{0, 0,   0,            0, 0,  0,  0,  0,  0,   0,            0,            0,            1,  6, 0, 4,  0,            3};
      vt[13] = '{0, 0,   0,            0, 0,  0,  0,  1,  0,   0,            0,            0,            0,  0, 0, 0,  0,            0};
      vt[14] = '{1, 9,   32'h55,       1, 9,  0,  0,  0,  1,   32'h55,       0,            0,            0,  0, 0, 0,  0,            0};
      vt[15] = '{0, 0,   0,            0, 0,  0,  0,  0,  0,   0,            0,            0,            0,  0, 0, 0,  0,            0};
      vt[16] = '{1, 505, 32'hDEAD,     0, 0,  0,  0,  0,  0,   0,            0,            0,            0,  0, 0, 0,  0,            0};
      vt[17] = '{0, 0,   0,            1, 505,0,  0,  0,  1,   32'hDEAD,     0,            0,            0,  0, 0, 0,  0,            0};
      vt[18] = '{0, 0,   0,            0, 0,  0,  0,  0,  0,   0,            0,            0,            0,  0, 0, 0,  0,            0};

      // Reset held, then release and time the zero-fill sweep
      @(negedge clk);
      rst_ = 1'b0;
      repeat (3) step();
      rst_ = 1'b1;
      #1;
      wait_ready(0, nm, na);
      chk("init_len_main", 32'(nm), 32'd512);
      chk("init_len_alt", 32'(na), 32'd500);

      // Directed vectors
      for (int k = 0; k < 19; k++) begin
         we = 1'(vt[k].we); wa = 9'(vt[k].wa); di = vt[k].di; re = 3'(vt[k].re);
         ra = {9'(vt[k].ra2), 9'(vt[k].ra1), 9'(vt[k].ra0)}; par_ctrl = 2'(vt[k].pc);
         step();
         xd = 3'(vt[k].x_dvld);
         chk($sformatf("vec%0d_dvld", k), 32'(dvld_m), 32'(xd));
         if (xd[0]) chk($sformatf("vec%0d_do0", k), do_m[31:0], vt[k].x_do0);
         if (xd[1]) chk($sformatf("vec%0d_do1", k), do_m[63:32], vt[k].x_do1);
         if (xd[2]) chk($sformatf("vec%0d_do2", k), do_m[95:64], vt[k].x_do2);
         chk($sformatf("vec%0d_err", k), 32'(err_m), vt[k].x_err);
         chk($sformatf("vec%0d_eaddr", k), 32'(eaddr_m), vt[k].x_eaddr);
         chk($sformatf("vec%0d_eport", k), 32'(eport_m), vt[k].x_eport);
         chk($sformatf("vec%0d_ecnt", k), 32'(ecnt_m), vt[k].x_ecnt);
         if (vt[k].re[0]) chk($sformatf("vec%0d_alt_do0", k), do_a[31:0], vt[k].x_ado0);
         chk($sformatf("vec%0d_alt_ecnt", k), 32'(ecnt_a), vt[k].x_acnt);
      end
      idle();

      // init_req in the middle of traffic: everything during the sweep is ignored
      we = 1'b1; wa = 9'd20; di = 32'h1234;
      step();
      idle();
      init_req = 1'b1;
      step();
      init_req = 1'b0;
      dseen = 0;
      for (int c = 0; c < 100; c++) begin
         we = 1'b1; wa = 9'($urandom_range(0, 31)); di = $urandom;
         re = 3'($urandom); ra = 27'($urandom);
         step();
         if (dvld_m != 3'b000) dseen++;
      end
      idle();
      chk("sweep_dvld_seen", 32'(dseen), 32'd0);
      wait_ready(100, nm, na);
      chk("reinit_len_main", 32'(nm), 32'd512);
      chk("reinit_len_alt", 32'(na), 32'd500);
      re = 3'b100; ra = {9'd20, 9'd0, 9'd0};
      step();
      chk("post_init_dvld2", 32'(dvld_m[2]), 32'd1);
      chk("post_init_do2", do_m[95:64], 32'd0);
      idle();

      // Reset in the middle of a sweep restarts it from the beginning
      init_req = 1'b1;
      step();
      init_req = 1'b0;
      repeat (200) step();
      rst_ = 1'b0;
      repeat (2) step();
      rst_ = 1'b1;
      #1;
      wait_ready(0, nm, na);
      chk("rst_mid_sweep_main", 32'(nm), 32'd512);
      chk("rst_mid_sweep_alt", 32'(na), 32'd500);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         we = 1'($urandom_range(0, 1));
         wa = rnd_addr();
         di = $urandom;
         re = 3'($urandom);
         ra = {rnd_addr(), rnd_addr(), rnd_addr()};
         par_ctrl = {1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0)};
         init_req = 1'($urandom_range(0, 999) == 0);
         step();
      end
      idle();
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/array_regpx_mp.md
Name: array_regpx_mp

Overview:
Parametrised single-clock register array with one write port and NRD read ports, each read port carrying its own per-entry parity check. It adds a hardware init sweep, so the array needs no reset and maps to RAM. It also adds a read-during-write bypass option, per-port read valids, and error diagnostics: first-error address and port capture plus a saturating error counter. It is the general storage primitive for per-channel context tables in datapath blocks.

Parameters:
ADDRBIT, 9, address width
DEPTH, 512, number of entries (DEPTH <= 2^ADDRBIT)
WIDTH, 32, data width
NRD, 3, number of read ports (1..4)
PORTBIT, 2, width of port index (2^PORTBIT >= NRD)
BYPASS, 1, 1: same-cycle read of the write address returns di; 0: returns old content
ERRCNTW, 8, parity error counter width

Ports:
clk  in  1  single clock, all logic on posedge
rst_  in  1  synchronous active-low reset
init_req  in  1  pulse: restart init sweep (honoured only in READY)
init_busy  out  1  high while sweep in progress
wa  in  ADDRBIT  write address
we  in  1  write enable
di  in  WIDTH  write data
re  in  NRD  per-port read enable
ra  in  NRD*ADDRBIT  read addresses, port p at [p*ADDRBIT +: ADDRBIT]
do  out  NRD*WIDTH  read data, port p at [p*WIDTH +: WIDTH]
dvld  out  NRD  per-port read data valid
par_ctrl  in  2  [0] clear error state; [1] disable parity update on write (error injection)
par_err  out  1  sticky parity error
par_err_addr  out  ADDRBIT  address of first error since clear
par_err_port  out  PORTBIT  port of first error since clear
par_err_cnt  out  ERRCNTW  saturating error count since clear

Behaviour:
- Reset: synchronous, active-low, single clock. Array contents and parity bits are not reset. All outputs are 0 while rst_=0, and the FSM is forced to INIT.
- FSM states: INIT, READY.
  - INIT: sweep counter runs from 0 to DEPTH-1, writing 0 data and parity 0, one entry per clk. init_busy=1 throughout. After the entry DEPTH-1 is written, the FSM moves to READY; total duration is DEPTH cycles.
  - READY: init_req=1 moves the FSM to INIT, with the counter restarting at 0.
  - While in INIT: we is ignored, re is ignored, dvld stays 0, and do holds its value.
- Write (READY only): when we=1 and wa<DEPTH, the entry is written with di. The parity bit is written with ^di only if par_ctrl[1]=0; otherwise the old parity bit is kept. A write with wa>=DEPTH is dropped.
- Read, port p: if re[p]=1 at cycle T, then do[p] and dvld[p]=1 appear at T+1. If re[p]=0, dvld[p]=0 and do[p] holds.
  - ra>=DEPTH: do[p]=0, dvld[p]=1, no parity check.
  - Same-cycle we=1 with wa==ra[p]: BYPASS=1 returns di; BYPASS=0 returns old data. A bypassed read is never parity-checked.
- Parity check: the stored parity bit is registered alongside do. At T+2, the flag is mismatch = dvld & checked & (par_bit ^ ^do[p]).
- Error state:
  - par_err is set on any mismatch and stays set.
  - On the first mismatch since clear, par_err_addr and par_err_port are captured. If several ports mismatch in that cycle, the lowest port index wins.
  - par_err_cnt adds the number of mismatching ports that cycle and saturates at all-ones.
  - par_ctrl[0]=1 clears all error state on the next cycle. A mismatch in the same cycle as clear is recorded as the first post-clear error: error wins over clear.
- Simultaneous reads of one address by several ports: all are served independently.
- init_req while in INIT: ignored.

Decomposition:
- Package array_regpx_pkg: FSM state encoding (ST_INIT, ST_READY); function for counting set bits of an NRD vector with saturating add.
- Sub-module array_regpx_rdport: one read port (output register, bypass mux, parity pipeline stage, mismatch flag). Instantiated NRD times via generate.
- Top module holds the array, parity vector, init FSM and error capture.

Test Plan:
- Reset release with DEPTH=512: init_busy=1 for exactly 512 cycles. A read of address 5 afterwards returns 0, dvld=1 at T+1, and par_err stays 0.
- Write 0xA5A5_0001 to address 7, then read all 3 ports at address 7 in one cycle: do = 0xA5A5_0001 on each port at T+1, no error.
- With par_ctrl[1]=1, write 0x1 to address 3 over prior 0; then read port 2 at address 3 at T: par_err=1 at T+2, par_err_addr=3, par_err_port=2, par_err_cnt=1.
- Injected errors at addresses 4 and 6 read by ports 1 and 0 in the same cycle: par_err_port=0, par_err_addr=6, cnt=2. Pulse par_ctrl[0]: all error state reads 0 the next cycle. Set ERRCNTW=2 and repeat: the count saturates at 3.
- we=1 with wa=ra[0]=9 and di=0x55: BYPASS=1 gives do[0]=0x55; BYPASS=0 gives the old value. No error flagged in either case.
- init_req mid-traffic: writes are dropped and dvld=0 for 512 cycles, after which all entries read 0. Assert rst_=0 mid-sweep: the sweep restarts from address 0.
